// File: rtl/intesn_pkg.sv
// Shared FSM encoding and arithmetic helpers for the integer echo state network reservoir.
package intesn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsmState_e;

  function automatic int unsigned idxWidth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned outWidth(input int unsigned dataWidth,
                                           input int unsigned weightSize,
                                           input int unsigned resSize);
    return dataWidth + weightSize + idxWidth(resSize);
  endfunction

  // Saturate to +/-kappa, further bounded by what a signed width-bit value can hold.
  function automatic int clip(input int value, input int kappa, input int width);
    int lim;
    lim = (1 << (width - 1)) - 1;
    if (kappa < lim) lim = kappa;
    if (value > lim) return lim;
    if (value < -lim) return -lim;
    return value;
  endfunction

endpackage

// File: rtl/int_esn_reservoir_if.sv
// Input handshake, weight-write port and result bus of the intESN reservoir.
interface int_esn_reservoir_if #(
  parameter int unsigned RES_SIZE    = 16,
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned WEIGHT_SIZE = 16,
  parameter int unsigned OUT_WIDTH   = 24
);
  localparam int unsigned IDX_W = intesn_pkg::idxWidth(RES_SIZE);

  logic                           iStart;
  logic                           iValid;
  logic                           oReady;
  logic [RES_SIZE-1:0]            iVec;
  logic                           iWe;
  logic [IDX_W-1:0]               iWAddr;
  logic [WEIGHT_SIZE-1:0]         iWData;
  logic                           oValid;
  logic [RES_SIZE*DATA_WIDTH-1:0] oState;
  logic [OUT_WIDTH-1:0]           oValue;

  modport master (
    output iStart, iValid, iVec, iWe, iWAddr, iWData,
    input  oReady, oValid, oState, oValue
  );

  modport slave (
    input  iStart, iValid, iVec, iWe, iWAddr, iWData,
    output oReady, oValid, oState, oValue
  );
endinterface

// File: rtl/intesn_lane.sv
// One neuron update: sign-extended shift-add of the bipolar input, then clip; optional weighted product.
module intesn_lane
  import intesn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned KAPPA       = 3
`ifdef INTESN_READOUT_EN
 ,parameter int unsigned WEIGHT_SIZE = 16
`endif
) (
  input  logic signed [DATA_WIDTH-1:0]             iPrev,
  input  logic                                     iBit,
`ifdef INTESN_READOUT_EN
  input  logic signed [WEIGHT_SIZE-1:0]            iWeight,
  output logic signed [DATA_WIDTH+WEIGHT_SIZE-1:0] oProd_c,
`endif
  output logic signed [DATA_WIDTH-1:0]             oNew_c
);
  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  logic signed [SUM_W-1:0] sum;

  // One guard bit so the +/-1 step can never wrap before clipping.
  assign sum    = $signed({iPrev[DATA_WIDTH-1], iPrev}) + (iBit ? SUM_W'(1) : SUM_W'(-1));
  assign oNew_c = DATA_WIDTH'(clip(int'(sum), int'(KAPPA), int'(DATA_WIDTH)));

`ifdef INTESN_READOUT_EN
  localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_SIZE;
  assign oProd_c = $signed(PROD_W'(oNew_c)) * $signed(PROD_W'(iWeight));
`endif

endmodule

// File: rtl/int_esn_reservoir.sv
// Integer echo state network reservoir, lane-serial update with clip; optional linear readout
// enabled by the INTESN_READOUT_EN compile-time macro.
module int_esn_reservoir
  import intesn_pkg::*;
#(
  parameter int unsigned RES_SIZE    = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned KAPPA       = 3,
  parameter int unsigned WEIGHT_SIZE = 16
) (
  input logic                iClk,
  input logic                iRst_n,
  int_esn_reservoir_if.slave bus
);
  localparam int unsigned CHUNKS    = RES_SIZE / LANES;
  localparam int unsigned IDX_W     = idxWidth(RES_SIZE);
  localparam int unsigned CNT_W     = idxWidth(CHUNKS);
  localparam int unsigned OUT_WIDTH = outWidth(DATA_WIDTH, WEIGHT_SIZE, RES_SIZE);

  fsmState_e                    fsmQ, fsmD;
  logic [CNT_W-1:0]             chunkQ, chunkD;
  logic                         accept, laneEn, commit;
  logic                         readyQ, validQ;
  logic [RES_SIZE-1:0]          vecQ;
  logic signed [DATA_WIDTH-1:0] xQ   [RES_SIZE];
  logic signed [DATA_WIDTH-1:0] bufQ [RES_SIZE];
  logic signed [DATA_WIDTH-1:0] laneNew [LANES];
  logic [IDX_W-1:0]             laneIdx [LANES];

  // Next-state and per-cycle control; iStart overrides everything.
  always_comb begin
    fsmD   = fsmQ;
    chunkD = chunkQ;
    accept = 1'b0;
    laneEn = 1'b0;
    commit = 1'b0;
    if (bus.iStart) begin
      fsmD   = IDLE;
      chunkD = '0;
    end else begin
      case (fsmQ)
        IDLE: begin
          if (bus.iValid) begin
            fsmD   = RUN;
            chunkD = '0;
            accept = 1'b1;
          end
        end
        RUN: begin
          laneEn = 1'b1;
          if (chunkQ == CNT_W'(CHUNKS - 1)) fsmD = DONE;
          else chunkD = chunkQ + CNT_W'(1);
        end
        DONE: begin
          commit = 1'b1;
          fsmD   = IDLE;
        end
        default: fsmD = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fsmQ   <= IDLE;
      chunkQ <= '0;
      readyQ <= 1'b1;
      validQ <= 1'b0;
    end else begin
      fsmQ   <= fsmD;
      chunkQ <= chunkD;
      readyQ <= (fsmD == IDLE);
      validQ <= commit;
    end
  end

`ifdef INTESN_READOUT_EN
  localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_SIZE;

  logic signed [WEIGHT_SIZE-1:0] wQ [RES_SIZE];
  logic signed [PROD_W-1:0]      laneProd [LANES];
  logic signed [OUT_WIDTH-1:0]   accQ, accNext, valueQ;

  // Weights change only while idle so a step always sees one consistent set.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < int'(RES_SIZE); i++) wQ[i] <= '0;
    end else if (bus.iWe && (fsmQ == IDLE)) begin
      wQ[bus.iWAddr] <= bus.iWData;
    end
  end

  always_comb begin
    accNext = accQ;
    for (int j = 0; j < int'(LANES); j++) accNext = accNext + OUT_WIDTH'(laneProd[j]);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      accQ   <= '0;
      valueQ <= '0;
    end else begin
      if (accept) accQ <= '0;
      else if (laneEn) accQ <= accNext;
      if (commit) valueQ <= accQ;
    end
  end

  assign bus.oValue = valueQ;
`else
  logic unusedWrite;
  assign unusedWrite = ^{bus.iWe, bus.iWAddr, bus.iWData};
  assign bus.oValue  = OUT_WIDTH'(0);
`endif

  // Lane j of chunk k updates neuron k*LANES+j from its ring predecessor.
  for (genvar j = 0; j < int'(LANES); j++) begin : gLane
    logic [IDX_W-1:0] curIdx, prevIdx;

    assign curIdx     = IDX_W'(int'(chunkQ) * int'(LANES) + j);
    assign prevIdx    = (curIdx == '0) ? IDX_W'(RES_SIZE - 1) : curIdx - IDX_W'(1);
    assign laneIdx[j] = curIdx;

    intesn_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .KAPPA      (KAPPA)
`ifdef INTESN_READOUT_EN
     ,.WEIGHT_SIZE(WEIGHT_SIZE)
`endif
    ) uLane (
      .iPrev   (xQ[prevIdx]),
      .iBit    (vecQ[curIdx]),
`ifdef INTESN_READOUT_EN
      .iWeight (wQ[curIdx]),
      .oProd_c (laneProd[j]),
`endif
      .oNew_c  (laneNew[j])
    );
  end

  // Committed state stays intact while the buffer fills; it is copied over on leaving DONE.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      vecQ <= '0;
      for (int i = 0; i < int'(RES_SIZE); i++) begin
        xQ[i]   <= '0;
        bufQ[i] <= '0;
      end
    end else if (bus.iStart) begin
      for (int i = 0; i < int'(RES_SIZE); i++) begin
        xQ[i]   <= '0;
        bufQ[i] <= '0;
      end
    end else begin
      if (accept) vecQ <= bus.iVec;
      if (laneEn) begin
        for (int j = 0; j < int'(LANES); j++) bufQ[laneIdx[j]] <= laneNew[j];
      end
      if (commit) begin
        for (int i = 0; i < int'(RES_SIZE); i++) xQ[i] <= bufQ[i];
      end
    end
  end

  for (genvar i = 0; i < int'(RES_SIZE); i++) begin : gState
    assign bus.oState[i*DATA_WIDTH +: DATA_WIDTH] = xQ[i];
  end

  assign bus.oReady = readyQ;
  assign bus.oValid = validQ;

endmodule

// File: tb/tb_int_esn_reservoir.sv
// Scoreboard bench for int_esn_reservoir: LANES=1 and LANES=2 instances, directed vectors.
module tb_int_esn_reservoir;
  localparam int unsigned RS = 4, DW = 3, WS = 16, OW = 21;
  localparam int CH1 = 4, CH2 = 2;
`ifdef INTESN_READOUT_EN
  localparam bit READOUT = 1'b1;
`else
  localparam bit READOUT = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [11:0] st;
    logic [20:0] val;
    int          at;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int_esn_reservoir_if #(.RES_SIZE(RS), .DATA_WIDTH(DW), .WEIGHT_SIZE(WS), .OUT_WIDTH(OW)) b1();
  int_esn_reservoir_if #(.RES_SIZE(RS), .DATA_WIDTH(DW), .WEIGHT_SIZE(WS), .OUT_WIDTH(OW)) b2();

  int_esn_reservoir #(.RES_SIZE(4), .LANES(1), .DATA_WIDTH(3), .KAPPA(3), .WEIGHT_SIZE(16))
    dut1 (.iClk(clk), .iRst_n(rstn), .bus(b1));
  int_esn_reservoir #(.RES_SIZE(4), .LANES(2), .DATA_WIDTH(3), .KAPPA(3), .WEIGHT_SIZE(16))
    dut2 (.iClk(clk), .iRst_n(rstn), .bus(b2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  function automatic logic [20:0] rv(input int v);
    return READOUT ? 21'(v) : 21'd0;
  endfunction

  // Monitors: pop and compare whenever a result strobe appears.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rstn && b1.oValid) begin
      if (q1.size() == 0) chk("spuriousValid1", b1.oValid, 0);
      else begin
        e = q1.pop_front();
        chk("state1", b1.oState, e.st);
        chk("value1", b1.oValue, e.val);
        chk("latency1", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rstn && b2.oValid) begin
      if (q2.size() == 0) chk("spuriousValid2", b2.oValid, 0);
      else begin
        e = q2.pop_front();
        chk("state2", b2.oState, e.st);
        chk("value2", b2.oValue, e.val);
        chk("latency2", cyc, e.at);
      end
    end
  end

  function automatic logic readyOf(input int d);
    return (d == 1) ? b1.oReady : b2.oReady;
  endfunction

  // Wait for ready, present one vector, and queue its expected result.
  task automatic step(input int d, input logic [3:0] v, input logic [11:0] st, input int val);
    int g = 0;
    exp_t e;
    while (readyOf(d) !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("readyWait%0d", d), readyOf(d), 1);
    e.st  = st;
    e.val = rv(val);
    e.at  = cyc + 1 + ((d == 1) ? CH1 : CH2) + 1;
    if (d == 1) begin b1.iVec = v; b1.iValid = 1'b1; q1.push_back(e); end
    else        begin b2.iVec = v; b2.iValid = 1'b1; q2.push_back(e); end
    @(negedge clk);
    b1.iValid = 1'b0;
    b2.iValid = 1'b0;
    chk($sformatf("readyLow%0d", d), readyOf(d), 0);
  endtask

  task automatic drain(input int d);
    int g = 0;
    while (((d == 1) ? q1.size() : q2.size()) != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("drain%0d", d), (d == 1) ? q1.size() : q2.size(), 0);
    @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [15:0] data);
    if (d == 1) begin b1.iWe = 1'b1; b1.iWAddr = a; b1.iWData = data; end
    else        begin b2.iWe = 1'b1; b2.iWAddr = a; b2.iWData = data; end
    @(negedge clk);
    b1.iWe = 1'b0;
    b2.iWe = 1'b0;
  endtask

  task automatic clear1();
    b1.iStart = 1'b1;
    @(negedge clk);
    b1.iStart = 1'b0;
  endtask

  initial begin
    b1.iStart = 0; b1.iValid = 0; b1.iVec = '0; b1.iWe = 0; b1.iWAddr = '0; b1.iWData = '0;
    b2.iStart = 0; b2.iValid = 0; b2.iVec = '0; b2.iWe = 0; b2.iWAddr = '0; b2.iWData = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rstReady", b1.oReady, 1);
    chk("rstValid", b1.oValid, 0);
    chk("rstState", b1.oState, 0);
    chk("rstValue", b1.oValue, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idleAfterReset", b1.oReady, 1);

    // Saturation: +1, +2, then pinned at +3
    step(1, 4'b1111, 12'h249, 0);
    step(1, 4'b1111, 12'h492, 0);
    step(1, 4'b1111, 12'h6DB, 0);
    step(1, 4'b1111, 12'h6DB, 0);
    step(1, 4'b1111, 12'h6DB, 0);
    drain(1);

    // Shift and clip from a cleared state
    clear1();
    chk("clearState", b1.oState, 0);
    step(1, 4'b0001, 12'hFF9, 0);
    step(1, 4'b0000, 12'hD86, 0);
    drain(1);

    // Readout: weights 1..4, all neurons +1
    clear1();
    wr(1, 2'd0, 16'd1);
    wr(1, 2'd1, 16'd2);
    wr(1, 2'd2, 16'd3);
    wr(1, 2'd3, 16'd4);
    step(1, 4'b1111, 12'h249, 10);
    drain(1);

    // Abort at k=1: no result, state cleared, weights kept
    b1.iVec = 4'b1111;
    b1.iValid = 1'b1;
    @(negedge clk);
    b1.iValid = 1'b0;
    @(negedge clk);
    b1.iStart = 1'b1;
    @(negedge clk);
    b1.iStart = 1'b0;
    chk("abortReady", b1.oReady, 1);
    chk("abortState", b1.oState, 0);
    repeat (6) @(negedge clk);
    step(1, 4'b1111, 12'h249, 10);
    drain(1);

    // LANES=2: shorter latency, and a write during RUN must be ignored
    wr(2, 2'd0, 16'd1);
    wr(2, 2'd1, 16'd1);
    wr(2, 2'd2, 16'd1);
    wr(2, 2'd3, 16'd1);
    step(2, 4'b1111, 12'h249, 4);
    wr(2, 2'd0, 16'd100);
    step(2, 4'b1111, 12'h492, 8);
    drain(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
